// File: rtl/noc_pkg.sv
// Shared NoC router parameters and allocator types.
package noc_pkg;

    localparam int PORT_N = 5;
    localparam int PORT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } alloc_st_e;

    // Width needed to hold a credit count in 0..n inclusive.
    function automatic int crd_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arb
    import noc_pkg::*;
#(
    parameter  int N  = PORT_N,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        grt = '0;
        idx = '0;
        any = |req;
        // Walk from the farthest offset back to ptr so the closest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grt    = '0;
                grt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/outport_alloc.sv
// Wormhole output-port allocator: locks one input for a whole packet, credit-gated.
module outport_alloc
    import noc_pkg::*;
#(
    parameter  int PORTID = 0,
    parameter  int CRD_N  = 4,
    localparam int CRD_W  = crd_w(CRD_N),
    localparam int IDX_W  = (PORT_N > 1) ? $clog2(PORT_N) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [PORT_N-1:0][PORT_W-1:0]  port_i,
    input  logic [PORT_N-1:0]              req_i,
    input  logic [PORT_N-1:0]              head_i,
    input  logic [PORT_N-1:0]              tail_i,
    input  logic                           crd_rtn_i,
    output logic [PORT_N-1:0]              sel_o,
    output logic [PORT_N-1:0]              ack_o,
    output logic                           vld_o,
    output logic [CRD_W-1:0]               crd_o
);

    alloc_st_e         state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [CRD_W-1:0]  crd_q,   crd_d;
    logic [PORT_N-1:0] sel_q,   sel_d;

    logic [PORT_N-1:0] elig;
    logic [PORT_N-1:0] grt;
    logic [IDX_W-1:0]  win;
    logic              any;
    logic              xfer;

    always_comb begin
        for (int i = 0; i < PORT_N; i++) begin
            elig[i] = req_i[i] & head_i[i] & (port_i[i] == PORT_W'(PORTID));
        end
    end

    rr_arb #(.N(PORT_N)) u_arb (
        .req (elig),
        .ptr (ptr_q),
        .grt (grt),
        .idx (win),
        .any (any)
    );

    assign xfer  = (state_q == LOCK) & req_i[owner_q] & (crd_q != '0);
    assign ack_o = sel_q & {PORT_N{xfer}};
    assign vld_o = xfer;
    assign sel_o = sel_q;
    assign crd_o = crd_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = LOCK;
                    owner_d = win;
                    sel_d   = grt;
                end
            end
            LOCK: begin
                if (xfer && tail_i[owner_q]) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    ptr_d   = (int'(owner_q) == PORT_N - 1) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A return at full credit saturates; it indicates an upstream bookkeeping bug.
    always_comb begin
        crd_d = crd_q;
        case ({xfer, crd_rtn_i})
            2'b10:   crd_d = crd_q - 1'b1;
            2'b01:   crd_d = (crd_q == CRD_W'(CRD_N)) ? crd_q : crd_q + 1'b1;
            default: crd_d = crd_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            crd_q   <= CRD_W'(CRD_N);
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            crd_q   <= crd_d;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(sel_q)) else $error("sel_o not onehot0: %b", sel_q);
            assert ((ack_o & ~sel_q) == '0) else $error("ack_o outside sel_o: %b", ack_o);
            assert (crd_q <= CRD_W'(CRD_N)) else $error("credit overflow: %0d", crd_q);
            assert (!(crd_rtn_i && !xfer && crd_q == CRD_W'(CRD_N)))
                else $error("credit returned while full");
        end
    end

endmodule

// File: tb/tb_outport_alloc.sv
// Directed bench for outport_alloc with PORTID=2, CRD_N=4.
module tb_outport_alloc;
    import noc_pkg::*;

    localparam int CRD_N = 4;
    localparam int CRD_W = crd_w(CRD_N);

    logic                          clk = 1'b0;
    logic                          rst;
    logic [PORT_N-1:0][PORT_W-1:0] port;
    logic [PORT_N-1:0]             req, head, tail;
    logic                          crd_rtn;
    logic [PORT_N-1:0]             sel, ack;
    logic                          vld;
    logic [CRD_W-1:0]              crd;

    int n_cmp = 0;
    int n_err = 0;

    outport_alloc #(.PORTID(2), .CRD_N(CRD_N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .port_i    (port),
        .req_i     (req),
        .head_i    (head),
        .tail_i    (tail),
        .crd_rtn_i (crd_rtn),
        .sel_o     (sel),
        .ack_o     (ack),
        .vld_o     (vld),
        .crd_o     (crd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input bit r, input bit h, input bit t, input int p);
        req[i]  = r;
        head[i] = h;
        tail[i] = t;
        port[i] = PORT_W'(p);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; crd_rtn = 1'b0; port = '0; req = '0; head = '0; tail = '0;
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_crd", 32'(crd), 4);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_vld", 32'(vld), 0);

        // Single requester: 3-flit packet from input 1
        drv(1, 1, 1, 0, 2); #1;
        chk("s1_idle_noack", 32'(ack), 0);
        tick();
        chk("s1_sel", 32'(sel), 5'b00010);
        chk("s1_ack_head", 32'(ack), 5'b00010);
        chk("s1_vld_head", 32'(vld), 1);
        chk("s1_crd4", 32'(crd), 4);
        tick(); drv(1, 1, 0, 0, 2); #1;
        chk("s1_ack_body", 32'(ack), 5'b00010);
        chk("s1_crd3", 32'(crd), 3);
        tick(); drv(1, 1, 0, 1, 2); #1;
        chk("s1_ack_tail", 32'(ack), 5'b00010);
        tick(); drv(1, 0, 0, 0, 0); #1;
        chk("s1_idle_sel", 32'(sel), 0);
        chk("s1_crd1", 32'(crd), 1);
        crd_rtn = 1'b1; tick(); tick(); tick(); crd_rtn = 1'b0; #1;
        chk("s1_crd_back", 32'(crd), 4);

        // Contention: inputs 0 and 3 with ptr reset to 0
        rst = 1'b1; tick(); rst = 1'b0;
        drv(0, 1, 1, 0, 2); drv(3, 1, 1, 1, 2);
        tick();
        chk("s2_sel0", 32'(sel), 5'b00001);
        chk("s2_ack0_head", 32'(ack), 5'b00001);
        tick(); drv(0, 1, 0, 1, 2); #1;
        chk("s2_ack0_tail", 32'(ack), 5'b00001);
        tick(); drv(0, 0, 0, 0, 0); #1;
        chk("s2_dead_sel", 32'(sel), 0);
        chk("s2_dead_ack", 32'(ack), 0);
        tick();
        chk("s2_sel3", 32'(sel), 5'b01000);
        chk("s2_ack3", 32'(ack), 5'b01000);
        tick(); drv(3, 0, 0, 0, 0); #1;
        chk("s2_idle", 32'(sel), 0);
        chk("s2_crd1", 32'(crd), 1);
        crd_rtn = 1'b1; tick(); tick(); tick(); crd_rtn = 1'b0;

        // ptr=4: single-flit packet on input 4 beats waiting input 2, then ptr wraps
        drv(4, 1, 1, 1, 2); drv(2, 1, 1, 1, 2);
        tick();
        chk("s4_sel4", 32'(sel), 5'b10000);
        chk("s4_ack4", 32'(ack), 5'b10000);
        tick(); drv(4, 0, 0, 0, 0); #1;
        chk("s4_idle", 32'(sel), 0);
        chk("s4_idle_ack", 32'(ack), 0);
        tick();
        chk("s4_sel2", 32'(sel), 5'b00100);
        chk("s4_ack2", 32'(ack), 5'b00100);
        tick(); drv(2, 0, 0, 0, 0); #1;
        chk("s4_idle2", 32'(sel), 0);
        chk("s4_crd2", 32'(crd), 2);
        crd_rtn = 1'b1; tick(); tick(); crd_rtn = 1'b0; #1;
        chk("s4_crd_back", 32'(crd), 4);

        // Credit stall: 6-flit packet from input 1, no returns
        drv(1, 1, 1, 0, 2);
        tick();
        chk("s3_sel", 32'(sel), 5'b00010);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s3_ack_f%0d", k), 32'(ack), 5'b00010);
            tick(); drv(1, 1, 0, 0, 2); #1;
        end
        chk("s3_stall_vld", 32'(vld), 0);
        chk("s3_stall_sel", 32'(sel), 5'b00010);
        chk("s3_stall_crd", 32'(crd), 0);
        tick();
        chk("s3_stall_ack", 32'(ack), 0);
        crd_rtn = 1'b1; #1;
        chk("s3_rtn_same_cycle", 32'(vld), 0);
        tick(); crd_rtn = 1'b0; #1;
        chk("s3_rtn_crd", 32'(crd), 1);
        chk("s3_rtn_vld", 32'(vld), 1);
        chk("s3_rtn_ack", 32'(ack), 5'b00010);
        tick();
        chk("s3_restall_vld", 32'(vld), 0);
        chk("s3_restall_crd", 32'(crd), 0);

        // Reset mid-packet
        rst = 1'b1; tick(); rst = 1'b0; drv(1, 0, 0, 0, 0);
        drv(3, 1, 1, 0, 2);
        tick();
        chk("s5_sel3", 32'(sel), 5'b01000);
        tick(); drv(3, 1, 0, 0, 2); rst = 1'b1; #1;
        tick(); rst = 1'b0; #1;
        chk("s5_rst_sel", 32'(sel), 0);
        chk("s5_rst_crd", 32'(crd), 4);
        chk("s5_rst_ack", 32'(ack), 0);

        // Route filtering, then simultaneous xfer and credit return
        drv(3, 0, 0, 0, 0); drv(1, 1, 1, 0, 3);
        tick();
        chk("s6_route_sel", 32'(sel), 0);
        drv(1, 0, 0, 0, 0); drv(0, 1, 1, 0, 2);
        tick();
        chk("s6_sel0", 32'(sel), 5'b00001);
        tick(); drv(0, 1, 0, 0, 2);
        tick(); #1;
        chk("s6_crd2", 32'(crd), 2);
        crd_rtn = 1'b1; #1;
        chk("s6_both_ack", 32'(ack), 5'b00001);
        tick(); crd_rtn = 1'b0; #1;
        chk("s6_both_crd", 32'(crd), 2);
        drv(0, 1, 0, 1, 2);
        tick(); drv(0, 0, 0, 0, 0); #1;
        chk("s6_end_sel", 32'(sel), 0);
        chk("s6_end_crd", 32'(crd), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
